// File: rtl/cory_arb4_wrr_pkg.sv
// Shared types and helpers for the 4-port weighted round-robin packet arbiter.
// Holds the arbiter state encoding and the round-pointer increment.
package cory_arb4_wrr_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_st_t;

  localparam int unsigned NPORT = 4;

  // Next port in round order; the 2-bit index wraps 3 -> 0 on its own.
  function automatic logic [1:0] next_port(input logic [1:0] p);
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/cory_arb4_wrr_rr_pick4.sv
// Combinational rotating-priority picker: the first requesting port at or after ptr wins.
// With no request, gnt_s reports ptr so the top can expose the idle round position.
module cory_rr_pick4
  import cory_arb4_wrr_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       gnt_v,
  output logic [1:0] gnt_s
);

  logic [1:0] idx_s;

  // Scan from farthest to nearest offset so the nearest requester is written last.
  always_comb begin
    gnt_v = 1'b0;
    gnt_s = ptr;
    idx_s = ptr;
    for (int i = NPORT - 1; i >= 0; i--) begin
      idx_s = ptr + 2'(i);
      if (req[idx_s]) begin
        gnt_v = 1'b1;
        gnt_s = idx_s;
      end else begin
        gnt_v = gnt_v;
      end
    end
  end

endmodule

// File: rtl/cory_arb4_wrr.sv
// 4-port weighted round-robin arbiter that holds a grant for a whole packet.
// The datapath is combinational; only the lock, round pointer and credit are stored.
module cory_arb4_wrr
  import cory_arb4_wrr_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_a0_v,
  input  logic [N-1:0] i_a0_d,
  input  logic         i_a0_l,
  output logic         o_a0_r,
  input  logic         i_a1_v,
  input  logic [N-1:0] i_a1_d,
  input  logic         i_a1_l,
  output logic         o_a1_r,
  input  logic         i_a2_v,
  input  logic [N-1:0] i_a2_d,
  input  logic         i_a2_l,
  output logic         o_a2_r,
  input  logic         i_a3_v,
  input  logic [N-1:0] i_a3_d,
  input  logic         i_a3_l,
  output logic         o_a3_r,
  input  logic [W-1:0] i_w0,
  input  logic [W-1:0] i_w1,
  input  logic [W-1:0] i_w2,
  input  logic [W-1:0] i_w3,
  output logic         o_z_v,
  output logic [N-1:0] o_z_d,
  output logic         o_z_l,
  output logic [1:0]   o_z_s,
  input  logic         i_z_r
);

  arb_st_t      st_r;
  logic [1:0]   sel_r;
  logic [1:0]   ptr_r;
  logic [W-1:0] cnt_r;

  logic [3:0]   v_s;
  logic [3:0]   l_s;
  logic [3:0]   req_s;
  logic [W-1:0] w_s [4];
  logic         gnt_v_s;
  logic [1:0]   gnt_s_s;
  logic [1:0]   eff_s;
  logic         act_s;
  logic [3:0]   rdy_s;
  logic         xfer_s;
  logic         done_s;
  logic [W-1:0] e_s;
  logic [W-1:0] e1_s;

  assign v_s    = {i_a3_v, i_a2_v, i_a1_v, i_a0_v};
  assign l_s    = {i_a3_l, i_a2_l, i_a1_l, i_a0_l};
  assign w_s[0] = i_w0;
  assign w_s[1] = i_w1;
  assign w_s[2] = i_w2;
  assign w_s[3] = i_w3;

  // Masked ports (weight 0) never compete.
  assign req_s = {v_s[3] & (i_w3 != '0), v_s[2] & (i_w2 != '0),
                  v_s[1] & (i_w1 != '0), v_s[0] & (i_w0 != '0)};

  cory_rr_pick4 u_pick (
    .req   (req_s),
    .ptr   (ptr_r),
    .gnt_v (gnt_v_s),
    .gnt_s (gnt_s_s)
  );

  // Effective select, per-port readies and credit arithmetic for the current beat.
  always_comb begin
    if (st_r == ARB_LOCK) begin
      eff_s = sel_r;
      act_s = ~reset;
    end else begin
      eff_s = gnt_s_s;
      act_s = gnt_v_s & ~reset;
    end
    rdy_s           = 4'b0000;
    rdy_s[eff_s]    = act_s & i_z_r;
    xfer_s          = act_s & v_s[eff_s] & i_z_r;
    done_s          = xfer_s & l_s[eff_s];
    if ((eff_s == ptr_r) && (cnt_r != '0)) begin
      e_s = cnt_r;
    end else begin
      e_s = w_s[eff_s];
    end
    // A port zeroed mid-packet has no credit left; treat it as exhausted.
    if (e_s == '0) begin
      e1_s = '0;
    end else begin
      e1_s = e_s - {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Output mux on the effective select.
  always_comb begin
    case (eff_s)
      2'd0:    begin o_z_d = i_a0_d; o_z_l = i_a0_l; end
      2'd1:    begin o_z_d = i_a1_d; o_z_l = i_a1_l; end
      2'd2:    begin o_z_d = i_a2_d; o_z_l = i_a2_l; end
      2'd3:    begin o_z_d = i_a3_d; o_z_l = i_a3_l; end
      default: begin o_z_d = '0;     o_z_l = 1'b0;   end
    endcase
  end

  assign o_z_v  = act_s & v_s[eff_s];
  assign o_z_s  = eff_s;
  assign o_a0_r = rdy_s[0];
  assign o_a1_r = rdy_s[1];
  assign o_a2_r = rdy_s[2];
  assign o_a3_r = rdy_s[3];

  // Packet lock FSM with round pointer and credit update on packet completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_r  <= ARB_IDLE;
      sel_r <= 2'd0;
      ptr_r <= 2'd0;
      cnt_r <= '0;
    end else if (done_s) begin
      st_r <= ARB_IDLE;
      if (e1_s == '0) begin
        ptr_r <= next_port(eff_s);
        cnt_r <= '0;
      end else begin
        ptr_r <= eff_s;
        cnt_r <= e1_s;
      end
    end else if (xfer_s) begin
      st_r  <= ARB_LOCK;
      sel_r <= eff_s;
    end else begin
      st_r <= st_r;
    end
  end

endmodule

// File: tb/tb_cory_arb4_wrr.sv
// Directed self-checking bench for cory_arb4_wrr with hand-computed expectations.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_cory_arb4_wrr;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] av, al;
  logic [7:0] ad [4];
  logic [3:0] w  [4];
  logic [3:0] ar;
  logic       z_v, z_l, z_r;
  logic [7:0] z_d;
  logic [1:0] z_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cory_arb4_wrr dut (
    .clk(clk), .reset(reset),
    .i_a0_v(av[0]), .i_a0_d(ad[0]), .i_a0_l(al[0]), .o_a0_r(ar[0]),
    .i_a1_v(av[1]), .i_a1_d(ad[1]), .i_a1_l(al[1]), .o_a1_r(ar[1]),
    .i_a2_v(av[2]), .i_a2_d(ad[2]), .i_a2_l(al[2]), .o_a2_r(ar[2]),
    .i_a3_v(av[3]), .i_a3_d(ad[3]), .i_a3_l(al[3]), .o_a3_r(ar[3]),
    .i_w0(w[0]), .i_w1(w[1]), .i_w2(w[2]), .i_w3(w[3]),
    .o_z_v(z_v), .o_z_d(z_d), .o_z_l(z_l), .o_z_s(z_s), .i_z_r(z_r)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_w(input logic [3:0] w0, w1, w2, w3);
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int seq1 [10] = '{0, 0, 1, 2, 3, 0, 0, 1, 2, 3};
    int seq3 [6]  = '{0, 1, 3, 0, 1, 3};
    int ptr4 [5]  = '{3, 3, 0, 3, 3};
    int zr5  [5]  = '{1, 0, 1, 0, 1};
    int idx;

    reset = 1'b1; av = 4'hF; al = 4'hF; z_r = 1'b1;
    for (int k = 0; k < 4; k++) ad[k] = 8'h10 + 8'(k);
    set_w(4'd1, 4'd1, 4'd1, 4'd1);
    @(negedge clk);
    tick();
    #1;
    chk("rst_zv", 32'(z_v), 32'd0);
    chk("rst_rdy", 32'(ar), 32'd0);
    reset = 1'b0; av = 4'h0;
    #1;
    chk("idle_zv", 32'(z_v), 32'd0);
    chk("idle_zs", 32'(z_s), 32'd0);
    @(negedge clk);

    // 1: weights 2,1,1,1, single-beat packets from all ports
    set_w(4'd2, 4'd1, 4'd1, 4'd1);
    av = 4'hF; al = 4'hF;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("t1_zv", 32'(z_v), 32'd1);
      chk("t1_zs", 32'(z_s), 32'(seq1[c]));
      chk("t1_zd", 32'(z_d), 32'h10 + 32'(seq1[c]));
      tick();
    end

    // 2: 4-beat packet on port0 while port1 waits
    set_w(4'd1, 4'd1, 4'd1, 4'd1);
    av = 4'b0011; al[1] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      ad[0] = 8'h40 + 8'(b); al[0] = (b == 3);
      #1;
      chk("t2_zs", 32'(z_s), 32'd0);
      chk("t2_zd", 32'(z_d), 32'h40 + 32'(b));
      chk("t2_r1", 32'(ar[1]), 32'd0);
      tick();
    end
    av = 4'b0010;
    #1;
    chk("t2_next_zs", 32'(z_s), 32'd1);
    chk("t2_next_r1", 32'(ar[1]), 32'd1);
    tick();
    av = 4'h0;

    // 3: port2 masked by weight 0
    do_reset();
    set_w(4'd1, 4'd1, 4'd0, 4'd1);
    av = 4'hF; al = 4'hF;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("t3_zs", 32'(z_s), 32'(seq3[c]));
      chk("t3_r2", 32'(ar[2]), 32'd0);
      tick();
    end
    av = 4'h0;

    // 4: only port3 valid, weight 3, five back-to-back packets
    do_reset();
    set_w(4'd1, 4'd1, 4'd1, 4'd3);
    av = 4'b1000; al = 4'hF;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t4_zv", 32'(z_v), 32'd1);
      chk("t4_zs", 32'(z_s), 32'd3);
      tick();
      chk("t4_ptr", 32'(dut.ptr_r), 32'(ptr4[c]));
    end
    av = 4'h0;
    #1;
    chk("t4_idle_zs", 32'(z_s), 32'd3);
    @(negedge clk);

    // 5: sink stalls mid-packet from port1; port0 arrives during the lock
    do_reset();
    set_w(4'd1, 4'd1, 4'd1, 4'd1);
    av = 4'b0010; al[0] = 1'b1; ad[0] = 8'h55;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) av = 4'b0011;
      z_r = zr5[c][0];
      ad[1] = 8'hA0 + 8'(idx); al[1] = (idx == 2);
      #1;
      chk("t5_zv", 32'(z_v), 32'd1);
      chk("t5_zs", 32'(z_s), 32'd1);
      chk("t5_zd", 32'(z_d), 32'hA0 + 32'(idx));
      chk("t5_r1", 32'(ar[1]), 32'(zr5[c]));
      chk("t5_r0", 32'(ar[0]), 32'd0);
      if (zr5[c] == 1) idx++;
      tick();
    end
    chk("t5_beats", 32'(idx), 32'd3);
    av = 4'b0001; z_r = 1'b1;
    #1;
    chk("t5_next_zs", 32'(z_s), 32'd0);
    chk("t5_next_zd", 32'(z_d), 32'h55);
    @(negedge clk);
    av = 4'h0;

    // 6: reset during beat 2 of a 4-beat port2 packet
    do_reset();
    av = 4'b0100;
    for (int b = 0; b < 2; b++) begin
      ad[2] = 8'hC0 + 8'(b); al[2] = 1'b0;
      #1;
      chk("t6_zs", 32'(z_s), 32'd2);
      tick();
    end
    ad[2] = 8'hC2;
    reset = 1'b1;
    #1;
    chk("t6_rst_zv", 32'(z_v), 32'd0);
    chk("t6_rst_r2", 32'(ar[2]), 32'd0);
    tick();
    reset = 1'b0;
    chk("t6_ptr", 32'(dut.ptr_r), 32'd0);
    av = 4'b0101; al[0] = 1'b1; ad[0] = 8'h77;
    #1;
    chk("t6_zs0", 32'(z_s), 32'd0);
    chk("t6_zd0", 32'(z_d), 32'h77);
    chk("t6_r2", 32'(ar[2]), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
